// File: rtl/soc_system_pulse_pio.sv
// Avalon-MM parallel output port with per-channel pulse generation: each channel
// can be driven statically and inverted for a programmable number of cycles on demand.
module soc_system_pulse_pio #(
  parameter int               WIDTH       = 8,
  parameter int               CNT_W       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA  = 3'd0;
  localparam logic [2:0] ADDR_SET   = 3'd1;
  localparam logic [2:0] ADDR_CLEAR = 3'd2;
  localparam logic [2:0] ADDR_PLEN  = 3'd3;
  localparam logic [2:0] ADDR_TRIG  = 3'd4;
  localparam logic [2:0] ADDR_BUSY  = 3'd5;

  logic             wr_en;
  logic             wr_data;
  logic             wr_set;
  logic             wr_clear;
  logic             wr_plen;
  logic             wr_trig;
  logic [WIDTH-1:0] wdata_w;
  logic [CNT_W-1:0] wdata_c;
  logic             unused_wdata;

  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] data_next;
  logic [CNT_W-1:0] plen_reg;
  logic [CNT_W-1:0] plen_next;
  logic             plen_nonzero;
  logic [WIDTH-1:0] busy_reg;
  logic [WIDTH-1:0] busy_next;
  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] out_next;

  assign wr_en    = chipselect && !write_n;
  assign wr_data  = wr_en && (address == ADDR_DATA);
  assign wr_set   = wr_en && (address == ADDR_SET);
  assign wr_clear = wr_en && (address == ADDR_CLEAR);
  assign wr_plen  = wr_en && (address == ADDR_PLEN);
  assign wr_trig  = wr_en && (address == ADDR_TRIG);

  assign wdata_w      = writedata[WIDTH-1:0];
  assign wdata_c      = writedata[CNT_W-1:0];
  // Upper write bits are deliberately discarded; fold them here so they are consumed.
  assign unused_wdata = ^writedata;

  assign plen_nonzero = (plen_reg != '0);

  always_comb begin
    data_next = data_reg;
    if (wr_data) begin
      data_next = wdata_w;
    end else if (wr_set) begin
      data_next = data_reg | wdata_w;
    end else if (wr_clear) begin
      data_next = data_reg & ~wdata_w;
    end
  end

  always_comb begin
    plen_next = plen_reg;
    if (wr_plen) begin
      plen_next = wdata_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg <= RESET_VALUE;
      plen_reg <= '0;
    end else begin
      data_reg <= data_next;
      plen_reg <= plen_next;
    end
  end

  // One saturating down-counter per channel; a trigger reloads it even mid-pulse.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;

      always_comb begin
        cnt_next = cnt_reg;
        if (wr_trig && writedata[gi] && plen_nonzero) begin
          cnt_next = plen_reg;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign busy_reg[gi]  = (cnt_reg != '0);
      assign busy_next[gi] = (cnt_next != '0);
    end
  endgenerate

  // Output is built from next-state values so it tracks data_reg ^ busy with no extra lag.
  assign out_next = data_next ^ busy_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg <= RESET_VALUE;
    end else begin
      out_reg <= out_next;
    end
  end

  assign out_port = out_reg;

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = data_reg;
      ADDR_PLEN: readdata[CNT_W-1:0] = plen_reg;
      ADDR_BUSY: readdata[WIDTH-1:0] = busy_reg;
      default:   readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_soc_system_pulse_pio.sv
// Directed bench for soc_system_pulse_pio: stimulus queues expected values,
// a negedge monitor pops and compares them against out_port / readdata.
module tb_soc_system_pulse_pio;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  soc_system_pulse_pio #(
    .WIDTH      (8),
    .CNT_W      (16),
    .RESET_VALUE(8'h00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  string       name_q[$];
  bit          kind_q[$];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always @(negedge clk) begin
    while (exp_q.size() != 0) begin
      string       nm;
      bit          is_rd;
      logic [31:0] ex;
      logic [31:0] act;
      nm    = name_q.pop_front();
      is_rd = kind_q.pop_front();
      ex    = exp_q.pop_front();
      act   = is_rd ? readdata : {24'h0, out_port};
      n_checks++;
      if (act !== ex) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, ex, $time);
      end else begin
        $display("ok   %s: 0x%08h (t=%0t)", nm, act, $time);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic chk_out(input string nm, input logic [7:0] v);
    name_q.push_back(nm);
    kind_q.push_back(1'b0);
    exp_q.push_back({24'h0, v});
  endtask

  // Sets the read address for the current cycle; caller must tick before the next write.
  task automatic chk_rd(input string nm, input logic [2:0] a, input logic [31:0] v);
    address = a;
    name_q.push_back(nm);
    kind_q.push_back(1'b1);
    exp_q.push_back(v);
  endtask

  initial begin
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk_out("rst_out", 8'h00);
    chk_rd("rst_data", 3'd0, 32'h0);
    tick();
    chk_rd("rst_plen", 3'd3, 32'h0);
    tick();
    chk_rd("rst_busy", 3'd5, 32'h0);
    tick();

    // DATA / SET / CLEAR
    write(3'd0, 32'h0000_01F0);
    chk_rd("data_trunc", 3'd0, 32'h0000_00F0);
    tick();
    write(3'd1, 32'h0000_0080);
    write(3'd2, 32'h0000_0010);
    chk_out("clr_out", 8'hE0);
    chk_rd("clr_data", 3'd0, 32'h0000_00E0);
    tick();
    chk_rd("rd_set", 3'd1, 32'h0);
    tick();
    chk_rd("rd_clear", 3'd2, 32'h0);
    tick();
    chk_rd("rd_trig", 3'd4, 32'h0);
    tick();
    chk_rd("rd_rsv6", 3'd6, 32'h0);
    tick();
    chk_rd("rd_rsv7", 3'd7, 32'h0);
    tick();

    // Single 3-cycle pulse on channel 0
    write(3'd0, 32'h0);
    write(3'd3, 32'hABCD_0003);
    chk_rd("plen_trunc", 3'd3, 32'h0000_0003);
    tick();
    write(3'd4, 32'h0000_0001);
    for (int i = 0; i < 5; i++) begin
      chk_out($sformatf("p3_out_c%0d", i), (i < 3) ? 8'h01 : 8'h00);
      chk_rd($sformatf("p3_busy_c%0d", i), 3'd5, (i < 3) ? 32'h1 : 32'h0);
      tick();
    end

    // Retrigger: 2 + 5 = 7 cycles on channel 1
    write(3'd3, 32'd5);
    write(3'd4, 32'h0000_0002);
    chk_out("rt_out_c0", 8'h02);
    tick();
    chk_out("rt_out_c1", 8'h02);
    write(3'd4, 32'h0000_0002);
    for (int i = 0; i < 6; i++) begin
      chk_out($sformatf("rt_out_c%0d", i + 2), (i < 5) ? 8'h02 : 8'h00);
      tick();
    end

    // Trigger with PLEN=0 does nothing
    write(3'd3, 32'd0);
    write(3'd4, 32'h0000_0002);
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("p0_out_c%0d", i), 8'h00);
      chk_rd($sformatf("p0_busy_c%0d", i), 3'd5, 32'h0);
      tick();
    end

    // Mid-pulse DATA write on channel 1
    write(3'd3, 32'd6);
    write(3'd4, 32'h0000_0002);
    chk_out("mid_out_pre", 8'h02);
    write(3'd0, 32'h0000_0002);
    for (int i = 0; i < 6; i++) begin
      chk_out($sformatf("mid_out_c%0d", i), (i < 5) ? 8'h00 : 8'h02);
      chk_rd($sformatf("mid_data_c%0d", i), 3'd0, 32'h2);
      tick();
    end

    // chipselect low and reserved-address writes are ignored
    address    = 3'd0;
    writedata  = 32'h0000_00FF;
    chipselect = 1'b0;
    write_n    = 1'b0;
    tick();
    write_n = 1'b1;
    chk_out("nocs_out", 8'h02);
    chk_rd("nocs_data", 3'd0, 32'h2);
    tick();
    write(3'd6, 32'h0000_00FF);
    chk_out("rsv_out", 8'h02);
    chk_rd("rsv_data", 3'd0, 32'h2);
    tick();
    chk_rd("rsv_plen", 3'd3, 32'd6);
    tick();
    chk_rd("rsv_busy", 3'd5, 32'h0);
    tick();

    // Reset during a 10-cycle pulse with a concurrent DATA write
    write(3'd3, 32'd10);
    write(3'd4, 32'h0000_0001);
    chk_out("pr_out_c0", 8'h03);
    tick();
    chk_out("pr_out_c1", 8'h03);
    reset      = 1'b1;
    address    = 3'd0;
    writedata  = 32'h0000_00FF;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    reset      = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    chk_out("ar_out", 8'h00);
    chk_rd("ar_busy", 3'd5, 32'h0);
    tick();
    chk_out("ar_out_c1", 8'h00);
    chk_rd("ar_data", 3'd0, 32'h0);
    tick();
    chk_rd("ar_plen", 3'd3, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("ar_nopulse_c%0d", i), 8'h00);
      tick();
    end

    // Multi-channel trigger over static pattern
    write(3'd1, 32'h0000_0005);
    chk_rd("mc_data", 3'd0, 32'h5);
    tick();
    write(3'd3, 32'd2);
    write(3'd4, 32'h0000_00FF);
    chk_out("mc_out_c0", 8'hFA);
    chk_rd("mc_busy_c0", 3'd5, 32'hFF);
    tick();
    chk_out("mc_out_c1", 8'hFA);
    tick();
    chk_out("mc_out_c2", 8'h05);
    chk_rd("mc_busy_c2", 3'd5, 32'h0);
    tick();

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(posedge clk);
    end
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/soc_system_pulse_pio.md
SOC_SYSTEM_PULSE_PIO -- requirements
Module: soc_system_pulse_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of output channels (1..32).
REQ-002 SHALL have parameter CNT_W, default 16, width of the pulse-length register and per-channel counters (1..32).
REQ-003 SHALL have parameter RESET_VALUE, default 0, WIDTH-bit reset value of the data register.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 address  in  3  Avalon-MM register index.
REQ-007 chipselect  in  1  slave select; access is ignored when low.
REQ-008 write_n  in  1  active-low write strobe.
REQ-009 writedata  in  32  write data.
REQ-010 readdata  out  32  read data, combinational from address (read latency 0).
REQ-011 out_port  out  WIDTH  channel outputs.

Function
REQ-012 A write SHALL occur on a rising edge when chipselect=1 and write_n=0; its effect SHALL be visible on out_port and readdata from the following cycle.
REQ-013 Register map SHALL be: 0 DATA (R/W), 1 SET (W), 2 CLEAR (W), 3 PLEN (R/W), 4 TRIG (W), 5 BUSY (R); addresses 6-7 are reserved.
REQ-014 DATA write SHALL load data_reg <= writedata[WIDTH-1:0].
REQ-015 SET write SHALL perform data_reg <= data_reg | writedata[WIDTH-1:0].
REQ-016 CLEAR write SHALL perform data_reg <= data_reg & ~writedata[WIDTH-1:0].
REQ-017 PLEN write SHALL load plen <= writedata[CNT_W-1:0].
REQ-018 Each channel i SHALL have a CNT_W-bit down-counter cnt[i]; busy[i] = (cnt[i] != 0).
REQ-019 TRIG write with writedata[i]=1 and plen!=0 SHALL load cnt[i] <= plen, whether the channel is idle or busy (a busy channel is retriggered).
REQ-020 TRIG write with plen=0, or with writedata[i]=0, SHALL leave cnt[i] unchanged.
REQ-021 On every cycle without a loading TRIG write for channel i, a nonzero cnt[i] SHALL decrement by 1; a zero cnt[i] SHALL hold at 0 and never wrap.
REQ-022 out_port[i] SHALL be a registered copy of data_reg[i] XOR busy[i], so a trigger with plen=L inverts out_port[i] for exactly L consecutive cycles, starting the cycle after the TRIG write.
REQ-023 DATA, SET or CLEAR writes during a pulse SHALL take effect on data_reg immediately, with out_port[i] = ~data_reg[i] until the pulse ends.
REQ-024 Reads SHALL return DATA={0,data_reg}, PLEN={0,plen}, BUSY={0,busy}; SET, CLEAR, TRIG and reserved addresses SHALL read 0.
REQ-025 readdata bits above WIDTH (or CNT_W for PLEN) SHALL read 0; writedata bits above them SHALL be ignored.
REQ-026 Writes to reserved addresses, and any access with chipselect=0, SHALL have no effect.

Reset
REQ-027 While reset=1 at a rising edge, the block SHALL set data_reg=RESET_VALUE, plen=0, all cnt=0, and out_port=RESET_VALUE; reset SHALL take priority over a simultaneous write.
REQ-028 Reset asserted during a pulse SHALL abort the pulse; out_port SHALL equal RESET_VALUE on the first cycle after reset and SHALL show no residual pulse.

Verification
REQ-029 Reset, WIDTH=8, RESET_VALUE=0x00 -> out_port=0x00, readdata@0=0, @3=0, @5=0.
REQ-030 Write DATA=0x1F0, SET=0x80, CLEAR=0x10 -> DATA reads 0xE0 after the CLEAR write, out_port=0xE0, readdata[31:8]=0.
REQ-031 PLEN=3, TRIG=0x01 with DATA=0x00 -> out_port[0]=1 for exactly 3 cycles, BUSY reads 0x01 during the pulse, then out_port=0x00 and BUSY=0.
REQ-032 PLEN=5, TRIG=0x02; retrigger TRIG=0x02 after 2 cycles -> bit 1 is high for 2+5=7 contiguous cycles; TRIG=0x02 with PLEN=0 -> no pulse.
REQ-033 Mid-pulse write DATA=0x02 on a pulsing channel 1 -> out_port[1]=0 until the counter expires, then 1; a write with chipselect=0 -> no change.
REQ-034 Reset asserted during a 10-cycle pulse, concurrent with a DATA write of 0xFF -> the next cycle out_port=0x00, BUSY=0, DATA reads 0x00.
